// File: rtl/ttt_turn_sequencer.sv
// rtl/ttt_turn_sequencer.sv - tic-tac-toe game controller: board, cursor, turn order, serial win check, scores
// One shared line comparator walks the 8 lines over 8 cycles after every placed mark.
module ttt_turn_sequencer #(
  parameter int   SCORE_W      = 12,
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               NewGame,
  input  logic               BtnL,
  input  logic               BtnR,
  input  logic               BtnU,
  input  logic               BtnD,
  input  logic               BtnC,
  output logic [17:0]        Board,
  output logic [3:0]         Cursor,
  output logic               Turn,
  output logic [3:0]         MoveCount,
  output logic               Invalid,
  output logic               Xwins,
  output logic               Owins,
  output logic               Draw,
  output logic [SCORE_W-1:0] P1s,
  output logic [SCORE_W-1:0] P2s,
  output logic               Qi,
  output logic               Qt,
  output logic               Qc,
  output logic               Qd
);

  typedef enum logic [1:0] {INI, TURN, CHK, DONE} state_t;

  state_t             state_q, state_d;
  logic [17:0]        board_q, board_d;
  logic [3:0]         cursor_q, cursor_d;
  logic               turn_q, turn_d;
  logic               start_player_q, start_player_d;
  logic [3:0]         move_count_q, move_count_d;
  logic               invalid_q, invalid_d;
  logic               xwins_q, xwins_d;
  logic               owins_q, owins_d;
  logic               draw_q, draw_d;
  logic [SCORE_W-1:0] p1s_q, p1s_d;
  logic [SCORE_W-1:0] p2s_q, p2s_d;
  logic [2:0]         line_q, line_d;

  logic [1:0] mark;
  logic [1:0] col;
  logic [3:0] la, lb, lc;
  logic       line_match;

  assign mark = turn_q ? 2'b10 : 2'b01;
  assign col  = 2'(cursor_q % 4'd3);

  always_comb begin
    la = 4'd0; lb = 4'd1; lc = 4'd2;
    case (line_q)
      3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
      3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
      3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
      3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
      3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
      3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
      3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
      default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
    endcase
    line_match = (board_q[{la, 1'b0} +: 2] == mark) &&
                 (board_q[{lb, 1'b0} +: 2] == mark) &&
                 (board_q[{lc, 1'b0} +: 2] == mark);
  end

  always_comb begin
    state_d        = state_q;
    board_d        = board_q;
    cursor_d       = cursor_q;
    turn_d         = turn_q;
    start_player_d = start_player_q;
    move_count_d   = move_count_q;
    invalid_d      = 1'b0;
    xwins_d        = xwins_q;
    owins_d        = owins_q;
    draw_d         = draw_q;
    p1s_d          = p1s_q;
    p2s_d          = p2s_q;
    line_d         = line_q;

    if (Start) begin
      start_player_d = FIRST_PLAYER;
      turn_d         = FIRST_PLAYER;
      board_d        = '0;
      cursor_d       = '0;
      move_count_d   = '0;
      xwins_d        = 1'b0;
      owins_d        = 1'b0;
      draw_d         = 1'b0;
      p1s_d          = '0;
      p2s_d          = '0;
      state_d        = TURN;
    end else if (NewGame && (state_q == TURN || state_q == DONE)) begin
      start_player_d = ~start_player_q;
      turn_d         = ~start_player_q;
      board_d        = '0;
      cursor_d       = '0;
      move_count_d   = '0;
      xwins_d        = 1'b0;
      owins_d        = 1'b0;
      draw_d         = 1'b0;
      state_d        = TURN;
    end else begin
      case (state_q)
        TURN: begin
          if (BtnC) begin
            if (board_q[{cursor_q, 1'b0} +: 2] != 2'b00) begin
              invalid_d = 1'b1;
            end else begin
              board_d[{cursor_q, 1'b0} +: 2] = mark;
              move_count_d = move_count_q + 4'd1;
              line_d       = 3'd0;
              state_d      = CHK;
            end
          end else if (BtnL) begin
            cursor_d = (col == 2'd0) ? cursor_q + 4'd2 : cursor_q - 4'd1;
          end else if (BtnR) begin
            cursor_d = (col == 2'd2) ? cursor_q - 4'd2 : cursor_q + 4'd1;
          end else if (BtnU) begin
            cursor_d = (cursor_q < 4'd3) ? cursor_q + 4'd6 : cursor_q - 4'd3;
          end else if (BtnD) begin
            cursor_d = (cursor_q > 4'd5) ? cursor_q - 4'd6 : cursor_q + 4'd3;
          end
        end
        CHK: begin
          if (line_match) begin
            if (turn_q) begin
              owins_d = 1'b1;
              if (p2s_q != '1) p2s_d = p2s_q + 1'b1;
            end else begin
              xwins_d = 1'b1;
              if (p1s_q != '1) p1s_d = p1s_q + 1'b1;
            end
            state_d = DONE;
          end else if (line_q == 3'd7) begin
            // A win on the ninth move has already been caught above, so this is a true draw.
            if (move_count_q == 4'd9) begin
              draw_d  = 1'b1;
              state_d = DONE;
            end else begin
              turn_d  = ~turn_q;
              state_d = TURN;
            end
          end else begin
            line_d = line_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= INI;
      board_q        <= '0;
      cursor_q       <= '0;
      turn_q         <= FIRST_PLAYER;
      start_player_q <= FIRST_PLAYER;
      move_count_q   <= '0;
      invalid_q      <= 1'b0;
      xwins_q        <= 1'b0;
      owins_q        <= 1'b0;
      draw_q         <= 1'b0;
      p1s_q          <= '0;
      p2s_q          <= '0;
      line_q         <= '0;
    end else begin
      state_q        <= state_d;
      board_q        <= board_d;
      cursor_q       <= cursor_d;
      turn_q         <= turn_d;
      start_player_q <= start_player_d;
      move_count_q   <= move_count_d;
      invalid_q      <= invalid_d;
      xwins_q        <= xwins_d;
      owins_q        <= owins_d;
      draw_q         <= draw_d;
      p1s_q          <= p1s_d;
      p2s_q          <= p2s_d;
      line_q         <= line_d;
    end
  end

  assign Board     = board_q;
  assign Cursor    = cursor_q;
  assign Turn      = turn_q;
  assign MoveCount = move_count_q;
  assign Invalid   = invalid_q;
  assign Xwins     = xwins_q;
  assign Owins     = owins_q;
  assign Draw      = draw_q;
  assign P1s       = p1s_q;
  assign P2s       = p2s_q;
  assign Qi        = (state_q == INI);
  assign Qt        = (state_q == TURN);
  assign Qc        = (state_q == CHK);
  assign Qd        = (state_q == DONE);

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// tb/tb_ttt_turn_sequencer.sv - randomized bench for ttt_turn_sequencer against a game-rules model
// A second instance with 2-bit scores exercises counter saturation on the same stimulus.
module tb_ttt_turn_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0, NewGame = 1'b0;
  logic BtnL = 1'b0, BtnR = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnC = 1'b0;

  logic [17:0] board, board2;
  logic [3:0]  cursor, cursor2, mc, mc2;
  logic        turn, turn2, inv, inv2, xw, xw2, ow, ow2, dr, dr2;
  logic [11:0] p1s, p2s;
  logic [1:0]  p1s2, p2s2;
  logic        qi, qt, qc, qd, qi2, qt2, qc2, qd2;

  ttt_turn_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .NewGame(NewGame),
    .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
    .Board(board), .Cursor(cursor), .Turn(turn), .MoveCount(mc), .Invalid(inv),
    .Xwins(xw), .Owins(ow), .Draw(dr), .P1s(p1s), .P2s(p2s),
    .Qi(qi), .Qt(qt), .Qc(qc), .Qd(qd)
  );

  ttt_turn_sequencer #(.SCORE_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .NewGame(NewGame),
    .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
    .Board(board2), .Cursor(cursor2), .Turn(turn2), .MoveCount(mc2), .Invalid(inv2),
    .Xwins(xw2), .Owins(ow2), .Draw(dr2), .P1s(p1s2), .P2s(p2s2),
    .Qi(qi2), .Qt(qt2), .Qc(qc2), .Qd(qd2)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: cells 0 empty / 1 X / 2 O; m_state 0 idle, 1 playing, 2 game over.
  int m_board[9];
  int m_turn, m_sp, m_mc, m_cur, m_xw, m_ow, m_dr, m_xn, m_on, m_state;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [17:0] exp_board();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
    return b;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic game_clear();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_cur = 0; m_mc = 0; m_xw = 0; m_ow = 0; m_dr = 0; m_turn = m_sp;
  endtask

  task automatic do_start();
    Start = 1'b1; @(negedge Clk); Start = 1'b0;
    m_sp = 0; m_xn = 0; m_on = 0; game_clear(); m_state = 1;
    checks++; if (qt !== 1'b1) begin errors++; $display("FAIL start_state got %0b exp 1", qt); end
    checks++; if (p1s !== 12'd0 || p2s !== 12'd0) begin errors++; $display("FAIL start_scores got %0d/%0d exp 0/0", p1s, p2s); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL start_turn got %0b exp 0", turn); end
  endtask

  task automatic do_newgame();
    NewGame = 1'b1; @(negedge Clk); NewGame = 1'b0;
    if (m_state != 0) begin m_sp ^= 1; game_clear(); m_state = 1; end
    checks++; if (qt !== (m_state == 1)) begin errors++; $display("FAIL newgame_state got %0b exp %0b", qt, m_state == 1); end
    checks++; if (turn !== 1'(m_turn)) begin errors++; $display("FAIL newgame_turn got %0b exp %0d", turn, m_turn); end
    checks++; if (board !== exp_board() || mc !== 4'(m_mc) || xw !== 1'b0) begin
      errors++; $display("FAIL newgame_clear got board %h mc %0d xw %0b exp board %h mc %0d xw 0", board, mc, xw, exp_board(), m_mc);
    end
  endtask

  task automatic press(input int dir);
    int r, c;
    case (dir)
      0: BtnL = 1'b1;
      1: BtnR = 1'b1;
      2: BtnU = 1'b1;
      default: BtnD = 1'b1;
    endcase
    @(negedge Clk);
    {BtnL, BtnR, BtnU, BtnD} = 4'b0;
    if (m_state == 1) begin
      r = m_cur / 3; c = m_cur % 3;
      case (dir)
        0: c = (c + 2) % 3;
        1: c = (c + 1) % 3;
        2: r = (r + 2) % 3;
        default: r = (r + 1) % 3;
      endcase
      m_cur = 3 * r + c;
    end
    checks++; if (cursor !== 4'(m_cur)) begin errors++; $display("FAIL cursor_move dir %0d got %0d exp %0d", dir, cursor, m_cur); end
  endtask

  task automatic goto_cell(input int t);
    int n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) press($urandom_range(0, 3));
    for (int i = 0; i < 3 && (m_cur % 3) != (t % 3); i++) press(1);
    for (int i = 0; i < 3 && (m_cur / 3) != (t / 3); i++) press(3);
  endtask

  task automatic do_move(input int t);
    int wl, d, exp_d;
    goto_cell(t);
    BtnC = 1'b1; @(negedge Clk); BtnC = 1'b0;
    if (m_board[t] != 0) begin
      checks++; if (inv !== 1'b1 || qt !== 1'b1) begin errors++; $display("FAIL invalid_pulse got inv %0b qt %0b exp 1 1", inv, qt); end
      checks++; if (board !== exp_board()) begin errors++; $display("FAIL invalid_board got %h exp %h", board, exp_board()); end
      @(negedge Clk);
      checks++; if (inv !== 1'b0) begin errors++; $display("FAIL invalid_width got %0b exp 0", inv); end
      return;
    end
    m_board[t] = m_turn + 1;
    m_mc++;
    wl = -1;
    for (int l = 7; l >= 0; l--)
      if (m_board[lines[l][0]] == m_turn + 1 && m_board[lines[l][1]] == m_turn + 1 &&
          m_board[lines[l][2]] == m_turn + 1) wl = l;
    exp_d = (wl >= 0) ? wl + 1 : 8;
    checks++; if (qc !== 1'b1 || board !== exp_board()) begin
      errors++; $display("FAIL place got qc %0b board %h exp 1 %h", qc, board, exp_board());
    end
    d = 0;
    for (int i = 1; i <= 12; i++) begin
      {BtnL, BtnR, BtnU, BtnD, BtnC} = 5'($urandom);
      @(negedge Clk);
      d = i;
      if (qc !== 1'b1) break;
    end
    {BtnL, BtnR, BtnU, BtnD, BtnC} = 5'b0;
    checks++; if (d !== exp_d) begin errors++; $display("FAIL check_latency got %0d exp %0d", d, exp_d); end
    if (wl >= 0) begin
      if (m_turn == 0) begin m_xw = 1; m_xn++; end else begin m_ow = 1; m_on++; end
      m_state = 2;
    end else if (m_mc == 9) begin
      m_dr = 1; m_state = 2;
    end else begin
      m_turn ^= 1;
    end
    checks++; if (qd !== (m_state == 2) || qt !== (m_state == 1)) begin
      errors++; $display("FAIL post_state got qt %0b qd %0b exp state %0d", qt, qd, m_state);
    end
    checks++; if ({xw, ow, dr} !== {1'(m_xw), 1'(m_ow), 1'(m_dr)}) begin
      errors++; $display("FAIL result_flags got %b%b%b exp %0d%0d%0d", xw, ow, dr, m_xw, m_ow, m_dr);
    end
    checks++; if (p1s !== 12'(sat(m_xn, 4095)) || p2s !== 12'(sat(m_on, 4095))) begin
      errors++; $display("FAIL scores got %0d/%0d exp %0d/%0d", p1s, p2s, m_xn, m_on);
    end
    checks++; if (p1s2 !== 2'(sat(m_xn, 3)) || p2s2 !== 2'(sat(m_on, 3))) begin
      errors++; $display("FAIL scores_sat got %0d/%0d exp %0d/%0d", p1s2, p2s2, sat(m_xn, 3), sat(m_on, 3));
    end
    checks++; if (turn !== 1'(m_turn) || mc !== 4'(m_mc) || cursor !== 4'(m_cur)) begin
      errors++; $display("FAIL post_move got turn %0b mc %0d cur %0d exp %0d %0d %0d", turn, mc, cursor, m_turn, m_mc, m_cur);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; @(negedge Clk); @(negedge Clk); Reset = 1'b0;
    m_state = 0; m_sp = 0; m_xn = 0; m_on = 0; game_clear();
    checks++; if ({qi, qt, qc, qd} !== 4'b1000) begin errors++; $display("FAIL reset_state got %b exp 1000", {qi, qt, qc, qd}); end
    checks++; if (board !== 18'd0 || cursor !== 4'd0 || mc !== 4'd0 || turn !== 1'b0) begin
      errors++; $display("FAIL reset_game got board %h cur %0d mc %0d turn %0b exp 0 0 0 0", board, cursor, mc, turn);
    end
    checks++; if ({inv, xw, ow, dr} !== 4'b0 || p1s !== 12'd0 || p2s !== 12'd0) begin
      errors++; $display("FAIL reset_flags got %b p1 %0d p2 %0d exp 0", {inv, xw, ow, dr}, p1s, p2s);
    end
    press(1);
    BtnC = 1'b1; NewGame = 1'b1; @(negedge Clk); BtnC = 1'b0; NewGame = 1'b0;
    checks++; if (qi !== 1'b1 || board !== 18'd0) begin errors++; $display("FAIL ini_ignores got qi %0b board %h exp 1 0", qi, board); end
  endtask

  task automatic test_row_win();
    do_start();
    do_move(0); do_move(3); do_move(1); do_move(4); do_move(2);
    checks++; if (xw !== 1'b1 || p1s !== 12'd1 || qd !== 1'b1) begin
      errors++; $display("FAIL row_win got xw %0b p1 %0d qd %0b exp 1 1 1", xw, p1s, qd);
    end
  endtask

  task automatic test_invalid();
    do_start();
    do_move(4); do_move(4);
    checks++; if (turn !== 1'b1 || mc !== 4'd1) begin errors++; $display("FAIL invalid_keep got turn %0b mc %0d exp 1 1", turn, mc); end
  endtask

  task automatic test_draw();
    int mv[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    do_start();
    foreach (mv[i]) do_move(mv[i]);
    checks++; if (dr !== 1'b1 || mc !== 4'd9 || p1s !== 12'd0 || p2s !== 12'd0) begin
      errors++; $display("FAIL draw got dr %0b mc %0d p %0d/%0d exp 1 9 0/0", dr, mc, p1s, p2s);
    end
  endtask

  task automatic test_diag_win();
    int mv[9] = '{1, 0, 3, 5, 2, 7, 6, 8, 4};
    do_start();
    foreach (mv[i]) do_move(mv[i]);
    checks++; if (xw !== 1'b1 || dr !== 1'b0) begin errors++; $display("FAIL diag_win got xw %0b dr %0b exp 1 0", xw, dr); end
    BtnC = 1'b1; BtnL = 1'b1; @(negedge Clk); BtnC = 1'b0; BtnL = 1'b0;
    checks++; if (qd !== 1'b1 || board !== exp_board() || cursor !== 4'(m_cur) || inv !== 1'b0) begin
      errors++; $display("FAIL done_hold got qd %0b board %h cur %0d exp 1 %h %0d", qd, board, cursor, exp_board(), m_cur);
    end
  endtask

  task automatic test_cursor();
    do_start();
    press(1); press(1); press(1);
    checks++; if (cursor !== 4'd0) begin errors++; $display("FAIL wrap_r got %0d exp 0", cursor); end
    press(3); press(3); press(3);
    checks++; if (cursor !== 4'd0) begin errors++; $display("FAIL wrap_d got %0d exp 0", cursor); end
    press(0);
    checks++; if (cursor !== 4'd2) begin errors++; $display("FAIL wrap_l got %0d exp 2", cursor); end
    press(1); press(2);
    checks++; if (cursor !== 4'd6) begin errors++; $display("FAIL wrap_u got %0d exp 6", cursor); end
    BtnC = 1'b1; BtnR = 1'b1; @(negedge Clk); BtnC = 1'b0; BtnR = 1'b0;
    checks++; if (cursor !== 4'd6 || board[13:12] !== 2'b01 || qc !== 1'b1) begin
      errors++; $display("FAIL c_over_r got cur %0d cell %b qc %0b exp 6 01 1", cursor, board[13:12], qc);
    end
    for (int i = 0; i < 12 && qc === 1'b1; i++) @(negedge Clk);
    m_board[6] = 1; m_mc = 1; m_turn = 1;
    checks++; if (qt !== 1'b1 || turn !== 1'b1) begin errors++; $display("FAIL c_over_r_pass got qt %0b turn %0b exp 1 1", qt, turn); end
  endtask

  task automatic test_saturate();
    int xg[5] = '{0, 3, 1, 4, 2};
    int og[6] = '{3, 0, 4, 1, 8, 2};
    do_start();
    for (int g = 0; g < 4; g++) begin
      if (g > 0) begin
        do_newgame();
        checks++; if (turn !== 1'(g % 2)) begin errors++; $display("FAIL ng_alternate got %0b exp %0d", turn, g % 2); end
      end
      if (g % 2 == 0) foreach (xg[i]) do_move(xg[i]);
      else            foreach (og[i]) do_move(og[i]);
    end
    checks++; if (p1s2 !== 2'd3 || p1s !== 12'd4) begin errors++; $display("FAIL saturate got %0d/%0d exp 3/4", p1s2, p1s); end
    do_start();
    checks++; if (p1s2 !== 2'd0 || turn !== 1'b0) begin errors++; $display("FAIL restart got p1 %0d turn %0b exp 0 0", p1s2, turn); end
  endtask

  task automatic test_reset_mid_chk();
    do_start();
    do_move(0); do_move(3); do_move(1); do_move(4);
    goto_cell(2);
    BtnC = 1'b1; @(negedge Clk); BtnC = 1'b0;
    @(negedge Clk);
    Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
    m_state = 0; m_sp = 0; m_xn = 0; m_on = 0; game_clear();
    repeat (3) @(negedge Clk);
    checks++; if (qi !== 1'b1 || p1s !== 12'd0 || xw !== 1'b0 || board !== 18'd0) begin
      errors++; $display("FAIL reset_mid_chk got qi %0b p1 %0d xw %0b board %h exp 1 0 0 0", qi, p1s, xw, board);
    end
  endtask

  task automatic test_random_games();
    int empt[$];
    do_start();
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 14 && m_state == 1; k++) begin
        empt.delete();
        for (int i = 0; i < 9; i++) if (m_board[i] == 0) empt.push_back(i);
        if (m_mc > 0 && $urandom_range(0, 7) == 0) begin
          for (int i = 0; i < 9; i++) if (m_board[i] != 0) begin do_move(i); break; end
        end else begin
          do_move(empt[$urandom_range(0, empt.size() - 1)]);
        end
      end
      do_newgame();
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    test_reset();
    test_row_win();
    test_invalid();
    test_draw();
    test_diag_win();
    test_cursor();
    test_saturate();
    test_reset_mid_chk();
    test_random_games();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
